// File: rtl/mux8lut_reg_stage.sv
// Registered output stage behind the 8-input MUX/LUT combiner: a 0/1/2-cycle
// pipeline on the four combiner outputs, with shared clock enable and sync set/reset.
(* FABulous,BelMap,c_reg0=0,c_reg1=1,c_reg2=2,c_reg3=3,c_depth=4,c_sr_en=5,c_sr_val=6,c_ce_en=7 *)
module mux8lut_reg_stage #(
    parameter int unsigned NoConfigBits = 8
) (
    input  logic                    UserCLK,
    input  logic                    RESETn,
    input  logic                    M_AB,
    input  logic                    M_AD,
    input  logic                    M_AH,
    input  logic                    M_EF,
    input  logic                    EN,
    input  logic                    SR,
    output logic                    Q_AB,
    output logic                    Q_AD,
    output logic                    Q_AH,
    output logic                    Q_EF,
    (* FABulous, GLOBAL *)
    input  logic [NoConfigBits-1:0] ConfigBits
);

    logic [3:0] c_reg;
    logic       c_depth;
    logic       c_sr_en;
    logic       c_sr_val;
    logic       c_ce_en;

    assign c_reg    = ConfigBits[3:0];
    assign c_depth  = ConfigBits[4];
    assign c_sr_en  = ConfigBits[5];
    assign c_sr_val = ConfigBits[6];
    assign c_ce_en  = ConfigBits[7];

    logic [3:0] m;
    logic [3:0] q;
    logic       ce;
    logic       sr_hit;

    assign m      = {M_EF, M_AH, M_AD, M_AB};
    assign ce     = c_ce_en ? EN : 1'b1;
    assign sr_hit = c_sr_en & SR;

    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;

    // SR loads both ranks so either depth shows the set/reset value after one edge.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (sr_hit) begin
            s1_d = {4{c_sr_val}};
            s2_d = {4{c_sr_val}};
        end else if (ce) begin
            s1_d = m;
            s2_d = s1_q;
        end
    end

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    always_comb begin
        q = m;
        for (int i = 0; i < 4; i++) begin
            if (c_reg[i]) begin
                q[i] = c_depth ? s2_q[i] : s1_q[i];
            end
        end
    end

    assign Q_AB = q[0];
    assign Q_AD = q[1];
    assign Q_AH = q[2];
    assign Q_EF = q[3];

endmodule

// File: tb/tb_mux8lut_reg_stage.sv
// Self-checking bench for mux8lut_reg_stage: directed scenarios plus randomized
// traffic checked against a history-based reference model.
module tb_mux8lut_reg_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] m;
    logic       en;
    logic       sr;
    logic [3:0] c_reg;
    logic       c_depth;
    logic       c_sr_en;
    logic       c_sr_val;
    logic       c_ce_en;
    logic [7:0] cfg;
    wire  [3:0] q;

    int tests = 0;
    int fails = 0;

    // Model: hist[0] is the most recently accepted word, hist[1] the one before.
    logic [3:0] hist[$];

    assign cfg = {c_ce_en, c_sr_val, c_sr_en, c_depth, c_reg};

    always #5 clk = ~clk;

    mux8lut_reg_stage #(.NoConfigBits(8)) dut (
        .UserCLK   (clk),
        .RESETn    (rst_n),
        .M_AB      (m[0]),
        .M_AD      (m[1]),
        .M_AH      (m[2]),
        .M_EF      (m[3]),
        .EN        (en),
        .SR        (sr),
        .Q_AB      (q[0]),
        .Q_AD      (q[1]),
        .Q_AH      (q[2]),
        .Q_EF      (q[3]),
        .ConfigBits(cfg)
    );

    function automatic logic [3:0] exp_q();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = c_reg[i] ? hist[c_depth ? 1 : 0][i] : m[i];
        end
        return r;
    endfunction

    function automatic void model_reset();
        hist = '{4'h0, 4'h0};
    endfunction

    function automatic void model_edge();
        if (!rst_n) return;
        if (c_sr_en && sr) begin
            hist = '{{4{c_sr_val}}, {4{c_sr_val}}};
        end else if (!c_ce_en || en) begin
            hist.push_front(m);
            void'(hist.pop_back());
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] r, input logic d, input logic se,
                           input logic sv, input logic ce);
        c_reg = r; c_depth = d; c_sr_en = se; c_sr_val = sv; c_ce_en = ce;
    endtask

    task automatic test_reset();
        set_cfg(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        m = 4'b1111; en = 1'b1; sr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        tests++;
        if (q !== 4'b0000) begin
            fails++; $display("FAIL reset_hold: q=%b expected=%b", q, 4'b0000);
        end
        tick();
        tests++;
        if (q !== 4'b0000) begin
            fails++; $display("FAIL reset_edge: q=%b expected=%b", q, 4'b0000);
        end
        #2 rst_n = 1'b1;
        tick();
        tests++;
        if (q !== 4'b1111) begin
            fails++; $display("FAIL reset_release: q=%b expected=%b", q, 4'b1111);
        end
    endtask

    task automatic test_depth();
        logic [3:0] vec[5] = '{4'b0101, 4'b1010, 4'b0011, 4'b0000, 4'b0000};
        for (int d = 1; d >= 0; d--) begin
            set_cfg(4'b1111, d[0], 1'b0, 1'b0, 1'b0);
            m = 4'b0000;
            tick(); tick();
            for (int k = 0; k < 5; k++) begin
                m = vec[k];
                tick();
                // Word applied at edge k-d appears after edge k (depth d+1).
                if (k >= d) begin
                    tests++;
                    if (q !== vec[k-d] || q !== exp_q()) begin
                        fails++;
                        $display("FAIL depth%0d_k%0d: q=%b expected=%b", d + 1, k, q, vec[k-d]);
                    end
                end
            end
        end
    endtask

    task automatic test_mixed_bypass();
        set_cfg(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        m = 4'b0000;
        tick();
        for (int k = 0; k < 6; k++) begin
            m = ~m;
            #1;
            tests++;
            if (q !== exp_q()) begin
                fails++; $display("FAIL mixed_comb_%0d: q=%b expected=%b", k, q, exp_q());
            end
            tick();
            tests++;
            if (q !== exp_q()) begin
                fails++; $display("FAIL mixed_edge_%0d: q=%b expected=%b", k, q, exp_q());
            end
        end
    endtask

    task automatic test_enable_stall();
        logic       stream[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       seen[$];
        set_cfg(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        m = 4'b0000; en = 1'b1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            m[2] = stream[k]; en = 1'b1;
            tick();
            if (k == 1) begin
                en = 1'b0; m = 4'b1011 ^ {1'b0, stream[k], 2'b00};
                for (int s = 0; s < 3; s++) begin
                    tick();
                    tests++;
                    if (q !== exp_q()) begin
                        fails++; $display("FAIL stall_hold_%0d: q=%b expected=%b", s, q, exp_q());
                    end
                end
                m = 4'b0000;
            end
            if (k >= 1) seen.push_back(q[2]);
        end
        m = 4'b0000; en = 1'b1;
        tick();
        seen.push_back(q[2]);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (seen[k] !== stream[k]) begin
                fails++; $display("FAIL stall_seq_%0d: q_ah=%b expected=%b", k, seen[k], stream[k]);
            end
        end
    endtask

    task automatic test_sr_priority();
        set_cfg(4'b1111, 1'b1, 1'b1, 1'b1, 1'b1);
        m = 4'b0000; en = 1'b1; sr = 1'b0;
        tick(); tick();
        sr = 1'b1; en = 1'b0;
        tick();
        tests++;
        if (q !== 4'b1111) begin
            fails++; $display("FAIL sr_set: q=%b expected=%b", q, 4'b1111);
        end
        sr = 1'b0; en = 1'b1;
        tick();
        tests++;
        if (q !== 4'b1111) begin
            fails++; $display("FAIL sr_drain1: q=%b expected=%b", q, 4'b1111);
        end
        tick();
        tests++;
        if (q !== 4'b0000) begin
            fails++; $display("FAIL sr_drain2: q=%b expected=%b", q, 4'b0000);
        end
        m = 4'b0110; sr = 1'b1; en = 1'b1;
        tick();
        tests++;
        if (q !== 4'b1111) begin
            fails++; $display("FAIL sr_beats_en: q=%b expected=%b", q, 4'b1111);
        end
        sr = 1'b0; m = 4'b0000;
        tick(); tick();
        c_sr_en = 1'b0; sr = 1'b1;
        tick(); tick();
        tests++;
        if (q !== 4'b0000) begin
            fails++; $display("FAIL sr_disabled: q=%b expected=%b", q, 4'b0000);
        end
        sr = 1'b0;
    endtask

    task automatic test_async_reset();
        set_cfg(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        m = 4'b1111; en = 1'b1; sr = 1'b0;
        tick(); tick(); tick();
        tests++;
        if (q !== 4'b1111) begin
            fails++; $display("FAIL async_fill: q=%b expected=%b", q, 4'b1111);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (q !== 4'b0000) begin
            fails++; $display("FAIL async_drop: q=%b expected=%b", q, 4'b0000);
        end
        #1 rst_n = 1'b1;
        tick();
        tests++;
        if (q !== 4'b0000) begin
            fails++; $display("FAIL async_post1: q=%b expected=%b", q, 4'b0000);
        end
        tick();
        tests++;
        if (q !== 4'b1111) begin
            fails++; $display("FAIL async_post2: q=%b expected=%b", q, 4'b1111);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (k % 25 == 0) begin
                set_cfg(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            m  = 4'($urandom);
            en = ($urandom_range(0, 3) != 0);
            sr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1 rst_n = 1'b1;
            end
            #1;
            tests++;
            if (q !== exp_q()) begin
                fails++; $display("FAIL rand_comb_%0d: q=%b expected=%b", k, q, exp_q());
            end
            tick();
            tests++;
            if (q !== exp_q()) begin
                fails++; $display("FAIL rand_edge_%0d: q=%b expected=%b", k, q, exp_q());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m = 4'b0000; en = 1'b0; sr = 1'b0;
        set_cfg(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_depth();
        test_mixed_bypass();
        test_enable_stall();
        test_sr_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
